rr_arbiter8_enc: RTL and testbench
==================================

Name: rr_arbiter8_enc

Overview:
- 8-requester round-robin arbiter with a binary-encoded grant output.
- Sits directly upstream of the team's 3-to-8 one-hot decoder: gnt_idx drives the decoder select, and gnt_valid gates the decoded enables.
- Holds a grant until the owner signals done, then rotates priority so every requester is served fairly.

Parameters:
- LAST_RESET, 7: reset value of the last-granted pointer. The default makes index 0 highest priority after reset. Legal range 0..7.
- TIMEOUT_CYC, 16: maximum grant length in cycles. Used only when ARB_TIMEOUT_EN is defined. Legal range 2..256.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  8  request vector; bit i = requester i wants the shared resource.
- done  in  1  release from the current owner; sampled only while gnt_valid=1.
- gnt_valid  out  1  grant active; gnt_idx is meaningful only when this is 1.
- gnt_idx  out  3  encoded index of the current or most recent winner.
- timeout  out  1  one-cycle pulse on a forced release. Tied 0 when the macro is absent; the port exists in both builds.

Interface rule (already decided): one clock; reset is asynchronous and active-high. Clock port is clk, reset port is rst.

Behaviour:
- Reset, asynchronous, effective without a clock edge:
  - state=IDLE, gnt_valid=0, gnt_idx=3'd0, timeout=0.
  - Internal last pointer = LAST_RESET; timeout counter = 0.
  - Deassertion is sampled at the next rising edge; no outputs change until then.
- FSM states: IDLE and GRANT. All outputs are registered.
- IDLE:
  - If req==0, stay in IDLE; outputs unchanged.
  - Otherwise the winner is the first set bit searching upward from last+1, wrapping modulo 8. The last pointer itself is searched last.
  - At that edge: gnt_idx<=winner, last<=winner, gnt_valid<=1, state<=GRANT.
  - Latency: req sampled at edge k gives gnt_valid=1 after edge k.
- GRANT:
  - gnt_idx and gnt_valid are held stable, regardless of req changes. Dropping the owner's req bit does not release the grant; only done releases it.
  - done=1 at an edge: gnt_valid<=0, state<=IDLE.
- Bubble: at least one cycle with gnt_valid=0 separates consecutive grants. This happens even if req is still nonzero and even when the same requester wins again.
- done while in IDLE is ignored.
- gnt_idx keeps the last winner after release. It is not cleared; consumers must qualify it with gnt_valid.
- Fairness:
  - A requester holding req continuously is granted within 7 intervening grants.
  - The sole requester is re-granted after every bubble.
- Priority search is pure combinational logic over req and last. There is no arithmetic beyond the 3-bit modulo-8 wrap of last+1.
- Simultaneous events: rst dominates everything. In GRANT, done and timeout expiry on the same edge count as a normal release with timeout=0.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - An 8-bit counter clears on entry to GRANT and increments on each GRANT cycle.
  - If the counter equals TIMEOUT_CYC-1 and done=0, the next edge forces a release: gnt_valid<=0, state<=IDLE, timeout<=1.
  - timeout is high for exactly that one IDLE cycle, then returns to 0.
  - Net effect: gnt_valid is high for at most TIMEOUT_CYC cycles.
  - last is still updated to the timed-out owner, so rotation continues past it.
- Undefined: no counter is implemented, timeout is constant 0, and a grant is held indefinitely until done.

Test Plan:
1. Reset:
   - rst=1 with no clock running -> gnt_valid=0, gnt_idx=0, timeout=0 immediately.
   - Release rst with req=0 for 5 cycles -> outputs unchanged.
2. Single grant:
   - After reset, req=8'h01 -> the edge after sampling gives gnt_valid=1, gnt_idx=0.
   - Hold 3 cycles with done=0 -> stable.
   - done=1 for 1 cycle -> gnt_valid=0 on the next cycle, gnt_idx still 0.
3. Full rotation:
   - req=8'hFF held, done=1 on every GRANT cycle -> gnt_idx sequence 0,1,2,3,4,5,6,7,0.
   - Each grant is 1 cycle, separated by 1-cycle bubbles.
4. Wrap:
   - After a grant to index 2 is released, req=8'b1000_0100 -> next grant 7; after its release -> grant 2.
   - Owner drops req mid-grant -> grant held until done.
5. Mid-grant reset:
   - During a grant to index 5, pulse rst between edges -> gnt_valid=0 without a clock edge.
   - Then req=8'h24 -> grant 2 (last reset to 7).
6. Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYC=4):
   - req=8'h10, done=0 -> gnt_valid high exactly 4 cycles, then timeout=1 for 1 cycle with gnt_valid=0.
   - The next cycle re-grants idx 4.
   - Without the macro -> the grant is held for 50 cycles and timeout stays 0.

Source files
------------

// File: rtl/rr_arbiter8_enc.sv
// 8-way round-robin arbiter with encoded grant; a grant is held until done, then priority rotates.
// Optional forced release after TIMEOUT_CYC grant cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter8_enc #(
  parameter int LAST_RESET  = 7,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic       gnt_valid,
  output logic [2:0] gnt_idx,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state_q, state_d;
  logic       gnt_valid_q, gnt_valid_d;
  logic [2:0] gnt_idx_q, gnt_idx_d;
  logic [2:0] last_q, last_d;
  logic [2:0] win;
  logic [2:0] cand;
  logic       hit;

`ifdef ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;
`endif

  if (LAST_RESET < 0 || LAST_RESET > 7 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 256) begin : g_bad_cfg
    $error("rr_arbiter8_enc: parameter out of range");
  end

  // Search upward from last+1; the 3-bit wrap makes last itself the final candidate.
  always_comb begin
    win  = last_q;
    cand = last_q;
    hit  = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      cand = last_q + 3'(k);
      if (req[cand] && !hit) begin
        win = cand;
        hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_valid_d = gnt_valid_q;
    gnt_idx_d   = gnt_idx_q;
    last_d      = last_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    timeout_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d     = GRANT;
          gnt_valid_d = 1'b1;
          gnt_idx_d   = win;
          last_d      = win;
`ifdef ARB_TIMEOUT_EN
          cnt_d       = 8'd0;
`endif
        end
      end
      GRANT: begin
        if (done) begin
          state_d     = IDLE;
          gnt_valid_d = 1'b0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT_CYC - 1)) begin
          state_d     = IDLE;
          gnt_valid_d = 1'b0;
          timeout_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= 3'd0;
      last_q      <= 3'(LAST_RESET);
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= 8'd0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_idx_q   <= gnt_idx_d;
      last_q      <= last_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q       <= cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign gnt_valid = gnt_valid_q;
  assign gnt_idx   = gnt_idx_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout   = timeout_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter8_enc.sv
// Testbench for rr_arbiter8_enc: directed scenarios plus random traffic against a behavioural model.
module tb_rr_arbiter8_enc;

  localparam int TCYC = 4;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       clk_en = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic       gnt_valid;
  logic [2:0] gnt_idx;
  logic       timeout;

  int errors = 0;
  int checks = 0;

  // Behavioural model: who owns the resource, for how long, and who was served last.
  int m_last;
  bit m_busy;
  int m_idx;
  bit m_tmo;
  int m_held;

  rr_arbiter8_enc #(.LAST_RESET(7), .TIMEOUT_CYC(TCYC)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt_valid(gnt_valid), .gnt_idx(gnt_idx), .timeout(timeout)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  function automatic int m_search(logic [7:0] r, int last);
    for (int k = 1; k <= 8; k++)
      if (r[(last + k) % 8]) return (last + k) % 8;
    return last;
  endfunction

  function automatic void model_reset();
    m_last = 7; m_busy = 0; m_idx = 0; m_tmo = 0; m_held = 0;
  endfunction

  function automatic void model_step(logic [7:0] r, logic d);
    if (!m_busy) begin
      m_tmo = 0;
      if (r != 8'h00) begin
        m_idx = m_search(r, m_last);
        m_last = m_idx;
        m_busy = 1;
        m_held = 1;
      end
    end else if (d) begin
      m_busy = 0;
      m_tmo = 0;
    end else if (TO_EN && m_held == TCYC) begin
      m_busy = 0;
      m_tmo = 1;
    end else begin
      m_held++;
    end
  endfunction

  task automatic tick();
    model_step(req, done);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; req = 8'h00; done = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    model_reset();
    rst = 1'b1;
    #1;
    checks++;
    if ({gnt_valid, gnt_idx, timeout} !== 5'b0_000_0) begin
      errors++;
      $display("FAIL reset_async: got v=%b idx=%0d to=%b, want v=0 idx=0 to=0", gnt_valid, gnt_idx, timeout);
    end
    clk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({gnt_valid, gnt_idx, timeout} !== 5'b0_000_0) begin
        errors++;
        $display("FAIL reset_idle_c%0d: got v=%b idx=%0d to=%b, want all 0", i, gnt_valid, gnt_idx, timeout);
      end
    end
  endtask

  task automatic test_single();
    req = 8'h01;
    tick();
    checks++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 3'd0) begin
      errors++;
      $display("FAIL single_grant: got v=%b idx=%0d, want v=1 idx=0", gnt_valid, gnt_idx);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (gnt_valid !== 1'b1 || gnt_idx !== 3'd0) begin
        errors++;
        $display("FAIL single_hold_c%0d: got v=%b idx=%0d, want v=1 idx=0", i, gnt_valid, gnt_idx);
      end
    end
    req = 8'h00; done = 1'b1;
    tick();
    done = 1'b0;
    checks++;
    if (gnt_valid !== 1'b0 || gnt_idx !== 3'd0) begin
      errors++;
      $display("FAIL single_release: got v=%b idx=%0d, want v=0 idx=0", gnt_valid, gnt_idx);
    end
  endtask

  task automatic test_rotation();
    int exp_seq[9] = '{0, 1, 2, 3, 4, 5, 6, 7, 0};
    apply_reset();
    req = 8'hFF; done = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick();
      checks++;
      if (gnt_valid !== 1'b1 || gnt_idx !== 3'(exp_seq[i]) || gnt_idx !== 3'(m_idx)) begin
        errors++;
        $display("FAIL rotate_grant_%0d: got v=%b idx=%0d, want v=1 idx=%0d", i, gnt_valid, gnt_idx, exp_seq[i]);
      end
      tick();
      checks++;
      if (gnt_valid !== 1'b0 || gnt_idx !== 3'(exp_seq[i])) begin
        errors++;
        $display("FAIL rotate_bubble_%0d: got v=%b idx=%0d, want v=0 idx=%0d", i, gnt_valid, gnt_idx, exp_seq[i]);
      end
    end
    done = 1'b0; req = 8'h00;
  endtask

  task automatic test_wrap();
    req = 8'h04;
    tick();
    done = 1'b1; tick(); done = 1'b0;
    checks++;
    if (gnt_valid !== 1'b0 || gnt_idx !== 3'd2) begin
      errors++;
      $display("FAIL wrap_setup: got v=%b idx=%0d, want v=0 idx=2", gnt_valid, gnt_idx);
    end
    req = 8'b1000_0100;
    tick();
    checks++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 3'd7) begin
      errors++;
      $display("FAIL wrap_grant7: got v=%b idx=%0d, want v=1 idx=7", gnt_valid, gnt_idx);
    end
    req = 8'b0000_0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (gnt_valid !== 1'b1 || gnt_idx !== 3'd7) begin
        errors++;
        $display("FAIL wrap_drop_hold_c%0d: got v=%b idx=%0d, want v=1 idx=7", i, gnt_valid, gnt_idx);
      end
    end
    req = 8'b1000_0100;
    done = 1'b1; tick(); done = 1'b0;
    tick();
    checks++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 3'd2) begin
      errors++;
      $display("FAIL wrap_grant2: got v=%b idx=%0d, want v=1 idx=2", gnt_valid, gnt_idx);
    end
    done = 1'b1; req = 8'h00; tick(); done = 1'b0;
  endtask

  task automatic test_midreset();
    apply_reset();
    req = 8'h20;
    tick();
    checks++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 3'd5) begin
      errors++;
      $display("FAIL midrst_grant5: got v=%b idx=%0d, want v=1 idx=5", gnt_valid, gnt_idx);
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({gnt_valid, gnt_idx, timeout} !== 5'b0_000_0) begin
      errors++;
      $display("FAIL midrst_async: got v=%b idx=%0d to=%b, want all 0", gnt_valid, gnt_idx, timeout);
    end
    rst = 1'b0;
    req = 8'h24;
    tick();
    checks++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 3'd2) begin
      errors++;
      $display("FAIL midrst_regrant: got v=%b idx=%0d, want v=1 idx=2", gnt_valid, gnt_idx);
    end
    done = 1'b1; req = 8'h00; tick(); done = 1'b0;
  endtask

  task automatic test_timeout();
    apply_reset();
    req = 8'h10;
    tick();
    checks++;
    if (gnt_valid !== 1'b1 || gnt_idx !== 3'd4 || timeout !== 1'b0) begin
      errors++;
      $display("FAIL to_grant: got v=%b idx=%0d to=%b, want v=1 idx=4 to=0", gnt_valid, gnt_idx, timeout);
    end
    if (TO_EN) begin
      for (int i = 0; i < TCYC - 1; i++) begin
        tick();
        checks++;
        if (gnt_valid !== 1'b1 || timeout !== 1'b0) begin
          errors++;
          $display("FAIL to_hold_c%0d: got v=%b to=%b, want v=1 to=0", i, gnt_valid, timeout);
        end
      end
      tick();
      checks++;
      if (gnt_valid !== 1'b0 || timeout !== 1'b1 || gnt_idx !== 3'd4) begin
        errors++;
        $display("FAIL to_pulse: got v=%b to=%b idx=%0d, want v=0 to=1 idx=4", gnt_valid, timeout, gnt_idx);
      end
      tick();
      checks++;
      if (gnt_valid !== 1'b1 || timeout !== 1'b0 || gnt_idx !== 3'd4) begin
        errors++;
        $display("FAIL to_regrant: got v=%b to=%b idx=%0d, want v=1 to=0 idx=4", gnt_valid, timeout, gnt_idx);
      end
    end else begin
      for (int i = 0; i < 50; i++) begin
        tick();
        checks++;
        if (gnt_valid !== 1'b1 || timeout !== 1'b0 || gnt_idx !== 3'd4) begin
          errors++;
          $display("FAIL noto_hold_c%0d: got v=%b to=%b idx=%0d, want v=1 to=0 idx=4", i, gnt_valid, timeout, gnt_idx);
        end
      end
    end
    done = 1'b1; req = 8'h00; tick(); done = 1'b0; tick();
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      req  = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      done = ($urandom_range(0, 2) == 0);
      tick();
      checks++;
      if ({gnt_valid, gnt_idx, timeout} !== {m_busy, 3'(m_idx), m_tmo}) begin
        errors++;
        $display("FAIL random_c%0d: got v=%b idx=%0d to=%b, want v=%b idx=%0d to=%b",
                 i, gnt_valid, gnt_idx, timeout, m_busy, m_idx, m_tmo);
      end
    end
    req = 8'h00; done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_midreset();
    test_timeout();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
